// File: rtl/alu_cu.sv
// ALU control unit: maps ALUOp/Fun6 to a registered 4-bit ALU operation select.
// Build option ALU_CU_NOR_EN enables decoding of Fun6=000111 to NOR.
module alu_cu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [5:0] Fun6,
  input  logic [1:0] ALUOp,
  output logic [3:0] Operation,
  output logic       out_valid,
  output logic       illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  // Returns {illegal, operation}; Fun6 is only examined for R-type so X on it
  // cannot leak into the fixed-class results.
  function automatic logic [4:0] decode(input logic [1:0] aluop, input logic [5:0] fun6);
    logic [4:0] res;
    res = {1'b0, OP_ADD};
    case (aluop)
      ALUOP_MEM:    res = {1'b0, OP_ADD};
      ALUOP_BRANCH: res = {1'b0, OP_SUB};
      ALUOP_RTYPE: begin
        case (fun6)
          6'b000000: res = {1'b0, OP_ADD};
          6'b000010: res = {1'b0, OP_SUB};
          6'b000100: res = {1'b0, OP_AND};
          6'b000101: res = {1'b0, OP_OR};
          6'b001010: res = {1'b0, OP_SLT};
`ifdef ALU_CU_NOR_EN
          6'b000111: res = {1'b0, OP_NOR};
`endif
          default:   res = {1'b1, OP_ADD};
        endcase
      end
      default:      res = {1'b1, OP_ADD};
    endcase
    return res;
  endfunction

  logic [3:0] dec_op_s;
  logic       dec_ill_s;
  logic [3:0] operation_r;
  logic       out_valid_r;
  logic       illegal_r;

  // Combinational decode of the current inputs.
  always_comb begin
    {dec_ill_s, dec_op_s} = decode(ALUOp, Fun6);
  end

  // Output registers; Operation holds across bubbles to avoid toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operation_r <= OP_ADD;
      out_valid_r <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (in_valid) begin
      operation_r <= dec_op_s;
      out_valid_r <= 1'b1;
      illegal_r   <= dec_ill_s;
    end else begin
      operation_r <= operation_r;
      out_valid_r <= 1'b0;
      illegal_r   <= 1'b0;
    end
  end

  assign Operation = operation_r;
  assign out_valid = out_valid_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_cu.sv
// Scoreboard bench for alu_cu: driver pushes expected results, monitor pops and compares.
module tb_alu_cu;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [5:0] Fun6;
  logic [1:0] ALUOp;
  logic [3:0] Operation;
  logic       out_valid;
  logic       illegal;

  typedef struct packed {
    logic [3:0] op;
    logic       ov;
    logic       il;
  } exp_t;

  exp_t q[$];
  int   rtype[int];
  int   tests = 0;
  int   fails = 0;
  logic [3:0] model_op;

  alu_cu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .Fun6(Fun6),
    .ALUOp(ALUOp), .Operation(Operation), .out_valid(out_valid), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] op, input logic ov, input logic il);
    tests++;
    if (Operation !== op || out_valid !== ov || illegal !== il) begin
      fails++;
      $display("FAIL %s: got op=%b ov=%b il=%b, want op=%b ov=%b il=%b",
               name, Operation, out_valid, illegal, op, ov, il);
    end
  endtask

  // Reference model: ALU op table by operation class, R-type by lookup table.
  task automatic issue(input logic v, input logic [5:0] f, input logic [1:0] a);
    exp_t e;
    logic [3:0] op;
    logic il;
    @(negedge clk);
    in_valid = v; Fun6 = f; ALUOp = a;
    if (!v) begin
      e = '{op: model_op, ov: 1'b0, il: 1'b0};
    end else begin
      il = 1'b0;
      op = 4'd2;
      if (a == 2'd1) op = 4'd6;
      else if (a == 2'd3) il = 1'b1;
      else if (a == 2'd2) begin
        if (rtype.exists(int'(f))) op = 4'(rtype[int'(f)]);
        else il = 1'b1;
      end
      model_op = op;
      e = '{op: op, ov: 1'b1, il: il};
    end
    q.push_back(e);
  endtask

  // Monitor: compare the DUT output of each cycle against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      check("sb", e.op, e.ov, e.il);
    end
  end

  initial begin
    logic [5:0] legal [5];
    rtype[0]  = 2;
    rtype[2]  = 6;
    rtype[4]  = 0;
    rtype[5]  = 1;
    rtype[10] = 7;
`ifdef ALU_CU_NOR_EN
    rtype[7]  = 12;
`endif
    legal[0] = 6'd0; legal[1] = 6'd2; legal[2] = 6'd4; legal[3] = 6'd5; legal[4] = 6'd10;
    model_op = 4'd2;
    rst_n = 1'b0; in_valid = 1'b0; Fun6 = 6'd0; ALUOp = 2'd0;

    repeat (3) @(posedge clk);
    #2 check("in_reset", 4'd2, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #2 check("after_release", 4'd2, 1'b0, 1'b0);

    // Fixed classes
    issue(1'b1, 6'b000000, 2'b00);
    issue(1'b1, 6'b000000, 2'b01);
    issue(1'b1, 6'b101010, 2'b01);
    // R-type sweep back to back
    for (int i = 0; i < 5; i++) issue(1'b1, legal[i], 2'b10);
    // Illegal decodes
    issue(1'b1, 6'b111111, 2'b10);
    issue(1'b1, 6'b010101, 2'b11);
    // Bubble after SLT
    issue(1'b1, 6'b001010, 2'b10);
    issue(1'b0, 6'b000100, 2'b10);
    issue(1'b0, 6'b000000, 2'b01);
    // NOR build option
    issue(1'b1, 6'b000111, 2'b10);
    issue(1'b1, 6'b000010, 2'b10);

    // Mid-stream asynchronous reset: SUB is loaded, then reset between edges
    issue(1'b1, 6'b000000, 2'b01);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset", 4'd2, 1'b0, 1'b0);
    model_op = 4'd2;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic v;
      logic [5:0] f;
      logic [1:0] a;
      v = ($urandom_range(0, 3) != 0);
      a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) f = legal[$urandom_range(0, 4)];
      else if ($urandom_range(0, 3) == 0) f = 6'b000111;
      else f = 6'($urandom);
      issue(v, f, a);
    end

    @(negedge clk) in_valid = 1'b0;
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
